// File: rtl/fft_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the FFT accelerator slave port between
// NR_MASTERS masters. A grant is held for a whole CYC tenure. A watchdog aborts
// any strobe the slave leaves unanswered, and the aborted master gets an error.
module fft_wb_arbiter #(
  parameter int unsigned NR_MASTERS = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NR_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NR_MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [NR_MASTERS-1:0]        m_we_i,
  input  logic [NR_MASTERS-1:0]        m_cyc_i,
  input  logic [NR_MASTERS-1:0]        m_stb_i,
  output logic [NR_MASTERS-1:0]        m_ack_o,
  output logic [NR_MASTERS-1:0]        m_err_o,
  output logic [DW-1:0]                m_dat_o,
  output logic [AW-1:0]                s_adr_o,
  output logic [DW-1:0]                s_dat_o,
  output logic [DW/8-1:0]              s_sel_o,
  output logic                         s_we_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic [DW-1:0]                s_dat_i,
  output logic [NR_MASTERS-1:0]        grant_o,
  output logic                         timeout_o
);

  localparam int unsigned IW     = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int unsigned SW     = DW / 8;
  localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

  state_e                r_state, w_state_nxt;
  logic [NR_MASTERS-1:0] r_grant;
  logic [IW-1:0]         r_gidx;
  logic [IW-1:0]         r_last;
  logic [15:0]           r_cnt, w_cnt_nxt;

  logic                  w_pick_vld;
  logic [IW-1:0]         w_pick_idx;
  logic [AW-1:0]         w_adr_g;
  logic [DW-1:0]         w_dat_g;
  logic [SW-1:0]         w_sel_g;
  logic                  w_we_g, w_cyc_g, w_stb_g;
  logic                  w_timeout;

  // Round-robin search: first requester at or after last+1, wrapping around.
  always_comb begin : rr_pick
    int unsigned v_idx;
    logic [IW-1:0] v_sel;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    v_idx      = 0;
    v_sel      = '0;
    for (int unsigned k = 1; k <= NR_MASTERS; k++) begin
      v_idx = (32'(r_last) + k) % NR_MASTERS;
      v_sel = IW'(v_idx);
      if (!w_pick_vld && m_cyc_i[v_sel]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = v_sel;
      end
    end
  end

  // Mux out the signals of the currently granted master.
  always_comb begin
    w_adr_g = '0;
    w_dat_g = '0;
    w_sel_g = '0;
    w_we_g  = 1'b0;
    w_cyc_g = 1'b0;
    w_stb_g = 1'b0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      if (r_gidx == IW'(i)) begin
        w_adr_g = m_adr_i[i*AW +: AW];
        w_dat_g = m_dat_i[i*DW +: DW];
        w_sel_g = m_sel_i[i*SW +: SW];
        w_we_g  = m_we_i[i];
        w_cyc_g = m_cyc_i[i];
        w_stb_g = m_stb_i[i];
      end
    end
  end

  // Watchdog: an ack or err in the limit cycle wins over the abort.
  always_comb begin
    w_timeout = (r_state == StGrant) && w_cyc_g && w_stb_g && !s_ack_i && !s_err_i &&
                (r_cnt == CntMax);
    w_cnt_nxt = '0;
    if ((r_state == StGrant) && w_cyc_g && w_stb_g && !s_ack_i && !s_err_i && !w_timeout) begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pick_vld) w_state_nxt = StGrant;
      end
      StGrant: begin
        if (!w_cyc_g)       w_state_nxt = StIdle;
        else if (w_timeout) w_state_nxt = StAbort;
      end
      StAbort: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, grant, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NR_MASTERS - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == StIdle) && w_pick_vld) begin
        r_gidx  <= w_pick_idx;
        r_grant <= NR_MASTERS'(1) << w_pick_idx;
      end else if ((r_state != StIdle) && (w_state_nxt == StIdle)) begin
        r_last  <= r_gidx;
        r_grant <= '0;
      end
    end
  end

  // Output decode: slave bus follows the owner only in GRANT; responses go to the owner only.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_dat_o   = '0;
    timeout_o = 1'b0;
    unique case (r_state)
      StGrant: begin
        s_adr_o = w_adr_g;
        s_dat_o = w_dat_g;
        s_sel_o = w_sel_g;
        s_we_o  = w_we_g;
        s_cyc_o = w_cyc_g;
        s_stb_o = w_stb_g;
        m_ack_o = r_grant & {NR_MASTERS{s_ack_i}};
        m_err_o = r_grant & {NR_MASTERS{s_err_i}};
        m_dat_o = s_dat_i;
      end
      StAbort: begin
        m_err_o   = r_grant;
        timeout_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_o = r_grant;

endmodule

// File: doc/fft_wb_arbiter.md
Name: fft_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single FFT accelerator slave port between NR_MASTERS bus masters.
- Typical masters: the network adapter's remote-access master and a local tile master.
- Grant is held for a whole Wishbone cycle (CYC high), so block and burst transfers are never interleaved.
- A watchdog aborts any transfer the FFT never acknowledges, returns an error to its master and releases the port.

Parameters:
- NR_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT, 255, cycles of STB without ACK/ERR before abort (1..65535).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m_adr_i  in  NR_MASTERS*AW  master addresses; master i occupies slice [AW*(i+1)-1 : AW*i].
- m_dat_i  in  NR_MASTERS*DW  master write data, same slicing.
- m_sel_i  in  NR_MASTERS*(DW/8)  master byte selects.
- m_we_i  in  NR_MASTERS  master write enables.
- m_cyc_i  in  NR_MASTERS  master cycle requests.
- m_stb_i  in  NR_MASTERS  master strobes.
- m_ack_o  out  NR_MASTERS  acknowledge, routed to the granted master only.
- m_err_o  out  NR_MASTERS  error, routed to the granted master only.
- m_dat_o  out  DW  read data, broadcast to all masters; valid only with own ack.
- s_adr_o  out  AW  address to FFT slave.
- s_dat_o  out  DW  write data to FFT slave.
- s_sel_o  out  DW/8  byte selects to FFT slave.
- s_we_o  out  1  write enable to FFT slave.
- s_cyc_o  out  1  cycle to FFT slave.
- s_stb_o  out  1  strobe to FFT slave.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- s_dat_i  in  DW  slave read data.
- grant_o  out  NR_MASTERS  registered one-hot grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, grant_o=0, s_cyc_o=s_stb_o=0, m_ack_o=m_err_o=0, timeout_o=0, counter=0.
  - last pointer = NR_MASTERS-1, so master 0 has first priority.
- FSM states: IDLE, GRANT, ABORT.
- IDLE:
  - The slave bus outputs (s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o) are driven to 0.
  - If any m_cyc_i is high, grant the first requester searching upward from last+1 (mod NR_MASTERS).
  - Grant is registered: a request sampled at edge N gives grant_o and s_cyc_o high in cycle N+1.
- GRANT:
  - s_adr/dat/sel/we/cyc/stb follow the granted master combinationally.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; all other masters see 0.
  - m_dat_o=s_dat_i.
  - Stay while m_cyc_i[g]=1, across any number of beats.
  - When m_cyc_i[g]=0: go to IDLE and set last=g.
  - IDLE always lasts at least one cycle, so s_cyc_o is low at least one cycle between tenures.
- Watchdog:
  - Counter increments each GRANT cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - It clears on ack, on err, or when stb is low.
  - When it reaches TIMEOUT-1 with no ack/err that cycle: next state is ABORT.
  - If ack and the timeout condition fall in the same cycle, ack wins: the transfer completes normally and the counter clears.
- ABORT (one cycle):
  - s_cyc_o=s_stb_o=0.
  - m_err_o[g]=1 and timeout_o=1 for exactly that cycle.
  - Next state is IDLE with last=g. If m_cyc_i[g] is still high, it re-enters arbitration as a normal requester.
- Ack/err beats from the slave while not in GRANT are ignored and never forwarded.
- A master that drops m_cyc_i while s_stb_o=1 ends its tenure; the slave sees cyc and stb fall in the same cycle.
- Non-granted masters receive no response and simply wait. There is no starvation: each master is served within NR_MASTERS tenures.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x0000_0010, slave acks after 2 cycles -> grant_o=01 one cycle after request; s_adr_o=0x10, s_dat_o=0xDEADBEEF; one m_ack_o[0] pulse; grant_o=00 after cyc drops.
- Contention: m0 and m1 both raise cyc at reset release -> m0 served first, then IDLE for 1 cycle, then m1. Repeat 4 times -> grants alternate 01,10,01,10.
- Burst hold: m1 holds cyc for 4 acked beats while m0 requests -> m0 gets no ack until m1 drops cyc; grant never changes mid-burst.
- Timeout: TIMEOUT=8, slave never acks m0's read -> exactly 8 stb cycles, then one cycle with m_err_o[0]=1, timeout_o=1, s_cyc_o=0; a pending m1 is granted afterwards.
- Ack/timeout race: ack arrives on the cycle the counter hits TIMEOUT-1 -> m_ack_o asserted, no err, no timeout_o.
- Reset mid-burst: assert rst during a GRANT with stb high -> all outputs 0 immediately; after release, master 0 has priority.
